// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl
//
// Bus-master front end that turns single-word command strobes into AXI4-Lite
// write or read transactions, one transaction at a time, and returns exactly
// one response strobe per accepted command.
//
// Parameters:
//   ADDR_WIDTH   - byte address width
//   DATA_WIDTH   - data width
//   STROBE_WIDTH - write byte-enable width
//   TIMEOUT      - cycles allowed in a response phase before giving up
//                  (0 = wait forever)
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   i_cmd_*         - command request (stb/wr/addr/data/strb), o_cmd_rdy accepts
//   o_rsp_*         - one-cycle response strobe with read data, xRESP code and
//                     a flag marking responses produced by the timeout
//   AW/W/B/AR/R     - AXI4-Lite master channels
module axi_lite_master_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 256
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_cmd_stb,
  output logic                    o_cmd_rdy,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,

  output logic                    o_rsp_stb,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,

  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,

  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,

  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,

  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,

  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = TIMEOUT[CNT_W-1:0];

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // The response phase gives up once the counter has reached TIMEOUT, so the
  // ready stays up for TIMEOUT+1 cycles and the strobe lands one cycle later.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_cmd_rdy     <= 1'b0;
      o_rsp_stb     <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= 2'b00;
      o_rsp_timeout <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= '0;
      o_wvalid      <= 1'b0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_araddr      <= '0;
      o_rready      <= 1'b0;
    end else begin
      o_rsp_stb <= 1'b0;

      case (state)
        IDLE: begin
          // Ready is registered, so the first IDLE cycle after reset only
          // raises it; commands are taken from the following cycle on.
          if (!o_cmd_rdy) begin
            o_cmd_rdy <= 1'b1;
          end else if (i_cmd_stb) begin
            o_cmd_rdy <= 1'b0;
            o_awaddr  <= i_cmd_addr;
            o_araddr  <= i_cmd_addr;
            o_wdata   <= i_cmd_data;
            o_wstrb   <= i_cmd_strb;
            if (i_cmd_wr) begin
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              o_arvalid <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W complete independently; a channel counts as done once
          // its valid is already low or handshakes this cycle.
          if (o_awvalid && i_awready) begin
            o_awvalid <= 1'b0;
          end
          if (o_wvalid && i_wready) begin
            o_wvalid <= 1'b0;
          end
          if ((!o_awvalid || i_awready) && (!o_wvalid || i_wready)) begin
            o_bready <= 1'b1;
            wait_cnt <= '0;
            state    <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (i_bvalid) begin
            o_bready      <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_resp    <= i_bresp;
            o_rsp_timeout <= 1'b0;
            o_rsp_stb     <= 1'b1;
            state         <= DONE;
          end else if (timeout_hit) begin
            o_bready      <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_resp    <= RESP_SLVERR;
            o_rsp_timeout <= 1'b1;
            o_rsp_stb     <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_REQ: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            wait_cnt  <= '0;
            state     <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (i_rvalid) begin
            o_rready      <= 1'b0;
            o_rsp_data    <= i_rdata;
            o_rsp_resp    <= i_rresp;
            o_rsp_timeout <= 1'b0;
            o_rsp_stb     <= 1'b1;
            state         <= DONE;
          end else if (timeout_hit) begin
            o_rready      <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_resp    <= RESP_SLVERR;
            o_rsp_timeout <= 1'b1;
            o_rsp_stb     <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          // The strobe was raised on entry; it falls here and the port reopens.
          o_cmd_rdy <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
# axi_lite_master_ctrl

Bus-master front end that turns single-word command strobes into AXI4-Lite write or read transactions. It drives the AXI-Lite master side of the link whose slave end is the `axi_lite_slave` register interface (for example inside `axi_lite_demo`). It returns one response strobe per command, carrying the read data and the `xRESP` code. It gives test benches and on-chip controllers a simple register-access port.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `STROBE_WIDTH`, `DATA_WIDTH/8`, write strobe width.
- `TIMEOUT`, 256, maximum cycles spent waiting in a response phase; 0 disables the timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_cmd_stb`  in  1  command valid.
- `o_cmd_rdy`  out  1  command accepted when `i_cmd_stb & o_cmd_rdy`.
- `i_cmd_wr`  in  1  1 = write, 0 = read.
- `i_cmd_addr`  in  `ADDR_WIDTH`  byte address.
- `i_cmd_data`  in  `DATA_WIDTH`  write data.
- `i_cmd_strb`  in  `STROBE_WIDTH`  write byte enables.
- `o_rsp_stb`  out  1  one-cycle response strobe.
- `o_rsp_data`  out  `DATA_WIDTH`  read data; 0 for writes.
- `o_rsp_resp`  out  2  BRESP or RRESP; `2'b10` on timeout.
- `o_rsp_timeout`  out  1  response was produced by the timeout.
- `o_awvalid`/`i_awready`/`o_awaddr`, `o_wvalid`/`i_wready`/`o_wdata`/`o_wstrb`, `i_bvalid`/`o_bready`/`i_bresp`, `o_arvalid`/`i_arready`/`o_araddr`, `i_rvalid`/`o_rready`/`i_rresp`/`i_rdata`: AXI4-Lite master channels, widths as named by the parameters.

## Operation
- States:
  - IDLE
  - WR_REQ
  - WR_RESP
  - RD_REQ
  - RD_RESP
  - DONE
- Outputs are registered.
- In IDLE, `o_cmd_rdy`=1. On accept, latch `addr`/`data`/`strb`/`wr`; go to WR_REQ if `wr`, else RD_REQ.
- WR_REQ:
  - Assert `o_awvalid` and `o_wvalid` together.
  - Each valid drops independently the cycle after its own handshake; AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: `o_bready`=1. On `i_bvalid`, capture `i_bresp`, set `o_rsp_data`=0, go to DONE.
- RD_REQ: `o_arvalid`=1 until `i_arready`, then go to RD_RESP.
- RD_RESP: `o_rready`=1. On `i_rvalid`, capture `i_rdata`/`i_rresp`, go to DONE.
- DONE: `o_rsp_stb`=1 for exactly one cycle, then IDLE.
- Timeout:
  - A counter clears on entry to WR_RESP or RD_RESP and increments every cycle without the response handshake.
  - When it reaches `TIMEOUT` (nonzero), drop the ready and go to DONE with `o_rsp_resp`=`2'b10`, `o_rsp_timeout`=1, `o_rsp_data`=0.
  - No timeout applies in WR_REQ or RD_REQ: AXI forbids withdrawing valid.
- Held values:
  - `o_awaddr`, `o_araddr`, `o_wdata` and `o_wstrb` stay stable from accept until the following accept.
  - `o_rsp_data`, `o_rsp_resp` and `o_rsp_timeout` hold until the next DONE.
- Commands arriving while `o_cmd_rdy`=0 are not accepted. The requester holds `i_cmd_stb` until accepted.
- Only one transaction is outstanding; there is no pipelining across commands.
- `rst` during any state:
  - Return to IDLE next edge.
  - All valids, readies and `o_rsp_stb` go to 0; no response is emitted for the aborted command.
  - Reset values: `o_cmd_rdy`=0 while `rst`=1, all AXI valid/ready 0, address/data/strb 0, `o_rsp_*` 0.
  - `o_cmd_rdy` rises the first cycle after `rst` deasserts.

## Timing
- Accept at edge N puts valids high in cycle N+1.
- Zero-wait write:
  - AW and W handshake at N+1.
  - `o_bready`=1 at N+2; with `i_bvalid` at N+2, `o_rsp_stb` at N+3.
  - `o_cmd_rdy` at N+4.
- Zero-wait read:
  - AR handshake at N+1.
  - `o_rready` at N+2; `o_rsp_stb` at N+3.
- Each slave wait cycle adds one cycle.
- Minimum command-to-command period is 4 cycles.
- Timeout: with `TIMEOUT`=T and no response, `o_rsp_stb` fires T+1 cycles after WR_RESP/RD_RESP entry.

## Test plan
- Zero-wait write: write `addr 0x0`, `data 0xDEADBEEF`, `strb 0xF`, slave always ready, `bresp 0` -> `o_awaddr`=0 and `o_wdata`=`0xDEADBEEF` handshake at N+1; `o_rsp_stb` at N+3 with resp 0, data 0.
- Split AW/W handshakes: `i_wready` at N+1, `i_awready` delayed to N+4 -> `o_wvalid` low from N+2, `o_awvalid` held until N+4; one B wait; a single `o_rsp_stb`.
- Readback against `axi_lite_demo`:
  - Write `0x12345678` to addr 4.
  - Read addr 4 -> `o_rsp_data`=`0x12345678`, resp 0.
  - Read addr 0 after reset -> `0x00000000`.
- Timeout: `TIMEOUT`=8, read with `i_arready`=1 but `i_rvalid` never -> `o_rready` drops; `o_rsp_stb` 9 cycles after RD_RESP entry with resp `2'b10`, `o_rsp_timeout`=1, data 0.
- Reset mid-write: assert `rst` while `o_awvalid`=1 -> next cycle all valids 0, no `o_rsp_stb`; `o_cmd_rdy`=1 the cycle after `rst` drops; a new read completes normally.
- Back-to-back commands: `i_cmd_stb` held high for 3 commands -> accepts spaced ≥4 cycles, exactly 3 `o_rsp_stb` pulses in order.
